uart_rx_frame_ctrl: RTL and testbench

- Receive-side frame controller for the UART peripheral.
- Sequences bit-timed sampling of UART_RXD: start-bit validation, mid-bit data sampling, parity check and stop check.
- Assembles the data word and presents it to the CPU/FIFO side over a valid/ready handshake, with per-frame error flags.
- Configured by the same CSR fields as the RX datapath: cd, number_data_receive, parity_bit_mode, stop_bit_twice, RXen.

---
 rtl/uart_pkg.sv | 38 +++
 rtl/uart_bit_timer.sv | 33 +++
 rtl/uart_rx_frame_ctrl.sv | 241 ++++++++++++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive frame controller.
//   rx_state_e : receive FSM states
//   rx_cfg_t   : per-frame configuration snapshot taken on IDLE->START
//   eff_nbits  : maps the data-bit CSR field onto a legal bit count
// The divisor field of rx_cfg_t is UART_CD_W bits wide; a top-level CD_W
// larger than that needs UART_CD_W raised to match.
package uart_pkg;

  localparam int UART_MIN_CD    = 2;
  localparam int UART_MAX_DBITS = 8;
  localparam int UART_CD_W      = 13;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } rx_state_e;

  typedef struct packed {
    logic [UART_CD_W-1:0] cd;      // effective (clamped) divisor
    logic [3:0]           nbits;   // effective data bits, 5..8
    logic                 par_en;
    logic                 par_odd;
    logic                 stop2;
  } rx_cfg_t;

  // Out-of-range bit counts fall back to a full byte.
  function automatic logic [3:0] eff_nbits(input logic [3:0] n);
    if (n >= 4'd5 && n <= 4'(UART_MAX_DBITS)) begin
      return n;
    end
    return 4'(UART_MAX_DBITS);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable down-counter that paces bit sampling.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   load_i        : load load_val_i (takes priority over counting)
//   load_val_i    : reload value
//   en_i          : count down while non-zero
//   tick_o        : high whenever the count is zero
module uart_bit_timer #(
  parameter int CD_W = 13
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_i,
  input  logic [CD_W-1:0] load_val_i,
  input  logic            en_i,
  output logic            tick_o
);

  logic [CD_W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CD_W'(1);
    end
  end

  // The count parks at zero, so tick stays high until the next load.
  assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: synchronizes UART_RXD, validates the start
// bit, samples data bits mid-bit LSB-first, checks parity and stop bits and
// presents the word over a valid/ready handshake with per-frame error flags.
// Optional build macro: UART_RX_MAJORITY_VOTE_EN (2-of-3 vote per sample
// point, state moves one cycle later, divisor clamped to at least 4).
// Ports:
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   UART_RXD               : serial line, idle high
//   RXen                   : receiver enable; dropping it aborts a frame
//   cd                     : clock cycles per bit
//   number_data_receive    : data bits per frame (5..8, else 8)
//   parity_bit_mode        : parity bit present
//   parity_odd             : 1 = odd parity, 0 = even parity
//   stop_bit_twice         : two stop bits
//   rx_data                : received word, LSB-aligned
//   rx_valid / rx_ready    : output handshake
//   parity_err, frame_err  : flags for the held word
//   overrun_err            : one-cycle pulse when an unread word is replaced
//   busy                   : FSM not in IDLE
module uart_rx_frame_ctrl
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CD_W        = 13
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            UART_RXD,
  input  logic            RXen,
  input  logic [CD_W-1:0] cd,
  input  logic [3:0]      number_data_receive,
  input  logic            parity_bit_mode,
  input  logic            parity_odd,
  input  logic            stop_bit_twice,
  output logic [7:0]      rx_data,
  output logic            rx_valid,
  input  logic            rx_ready,
  output logic            parity_err,
  output logic            frame_err,
  output logic            overrun_err,
  output logic            busy
);

`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam logic [CD_W-1:0] CD_MIN = CD_W'(4);
`else
  localparam logic [CD_W-1:0] CD_MIN = CD_W'(UART_MIN_CD);
`endif

  // Line synchronizer; resets to the idle level so reset never looks like a start edge.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   line_s;

  assign line_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], UART_RXD};
      prev_q <= line_s;
    end
  end

  rx_state_e       state_q;
  rx_cfg_t         cfg_q;
  logic [7:0]      data_q;
  logic [2:0]      bit_cnt_q;
  logic            par_acc_q;
  logic            perr_c_q;
  logic            ferr_c_q;
  logic [7:0]      rx_data_q;
  logic            rx_valid_q;
  logic            perr_q;
  logic            ferr_q;
  logic            overrun_q;

  logic            tick;
  logic            start_go;
  logic            sample_now;
  logic            sample_bit;
  logic            done;
  logic [CD_W-1:0] cd_e_d;
  logic [CD_W-1:0] reload_d;
  logic [CD_W-1:0] timer_val_d;
  logic            timer_load_d;
  rx_cfg_t         cfg_d;

`ifdef UART_RX_MAJORITY_VOTE_EN
  // h1_q/h2_q hold the line at the count==0 and count==1 cycles when the
  // post-expiry cycle (vote_q) takes the majority.
  logic h1_q;
  logic h2_q;
  logic vote_q;
  logic vote_d;

  assign vote_d = tick && (state_q != IDLE) && !vote_q && RXen;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      h1_q   <= 1'b1;
      h2_q   <= 1'b1;
      vote_q <= 1'b0;
    end else begin
      h1_q   <= line_s;
      h2_q   <= h1_q;
      vote_q <= vote_d;
    end
  end
`endif

  always_comb begin
    cd_e_d   = (cd < CD_MIN) ? CD_MIN : cd;
    start_go = (state_q == IDLE) && RXen && prev_q && !line_s;

    cfg_d.cd      = UART_CD_W'(cd_e_d);
    cfg_d.nbits   = eff_nbits(number_data_receive);
    cfg_d.par_en  = parity_bit_mode;
    cfg_d.par_odd = parity_odd;
    cfg_d.stop2   = stop_bit_twice;

`ifdef UART_RX_MAJORITY_VOTE_EN
    sample_now = vote_q && (state_q != IDLE);
    sample_bit = (h2_q & h1_q) | (h2_q & line_s) | (h1_q & line_s);
    // Reloading one cycle late, so one less keeps the bit period at cd_e.
    reload_d   = CD_W'(cfg_q.cd) - CD_W'(2);
`else
    sample_now = tick && (state_q != IDLE);
    sample_bit = line_s;
    reload_d   = CD_W'(cfg_q.cd) - CD_W'(1);
`endif

    timer_load_d = start_go || sample_now;
    timer_val_d  = start_go ? ((cd_e_d >> 1) - CD_W'(1)) : reload_d;

    done = sample_now && RXen &&
           (((state_q == STOP1) && !cfg_q.stop2) || (state_q == STOP2));
  end

  uart_bit_timer #(
    .CD_W (CD_W)
  ) u_bit_timer (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (timer_load_d),
    .load_val_i (timer_val_d),
    .en_i       (state_q != IDLE),
    .tick_o     (tick)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cfg_q      <= '0;
      data_q     <= '0;
      bit_cnt_q  <= '0;
      par_acc_q  <= 1'b0;
      perr_c_q   <= 1'b0;
      ferr_c_q   <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end

      if ((state_q != IDLE) && !RXen) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (start_go) begin
              state_q   <= START;
              cfg_q     <= cfg_d;
              data_q    <= '0;
              bit_cnt_q <= '0;
              par_acc_q <= 1'b0;
              perr_c_q  <= 1'b0;
              ferr_c_q  <= 1'b0;
            end
          end
          START: begin
            // A high line at mid-start is a glitch: drop back and wait for a new edge.
            if (sample_now) begin
              state_q <= sample_bit ? IDLE : DATA;
            end
          end
          DATA: begin
            if (sample_now) begin
              data_q[bit_cnt_q] <= sample_bit;
              par_acc_q         <= par_acc_q ^ sample_bit;
              bit_cnt_q         <= bit_cnt_q + 3'd1;
              if ({1'b0, bit_cnt_q} == (cfg_q.nbits - 4'd1)) begin
                state_q <= cfg_q.par_en ? PARITY : STOP1;
              end
            end
          end
          PARITY: begin
            if (sample_now) begin
              perr_c_q <= ((par_acc_q ^ sample_bit) != cfg_q.par_odd);
              state_q  <= STOP1;
            end
          end
          STOP1: begin
            if (sample_now && cfg_q.stop2) begin
              ferr_c_q <= ferr_c_q | ~sample_bit;
              state_q  <= STOP2;
            end
          end
          STOP2: ;
          default: state_q <= IDLE;
        endcase
      end

      // Completion overrides the acceptance clear above, so a word landing
      // in the acceptance cycle keeps rx_valid high without an overrun.
      if (done) begin
        state_q    <= IDLE;
        rx_data_q  <= data_q;
        perr_q     <= perr_c_q;
        ferr_q     <= ferr_c_q | ~sample_bit;
        rx_valid_q <= 1'b1;
        overrun_q  <= rx_valid_q && !rx_ready;
      end
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign parity_err  = perr_q;
  assign frame_err   = ferr_q;
  assign overrun_err = overrun_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
module tb_uart_rx_frame_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        UART_RXD = 1'b1;
  logic        RXen = 1'b0;
  logic [12:0] cd = 13'd4;
  logic [3:0]  number_data_receive = 4'd8;
  logic        parity_bit_mode = 1'b0;
  logic        parity_odd = 1'b0;
  logic        stop_bit_twice = 1'b0;
  logic        rx_ready = 1'b1;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        parity_err;
  logic        frame_err;
  logic        overrun_err;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rise_cnt = 0;
  int rise_cyc = 0;
  int vld_cnt = 0;
  int ovr_cnt = 0;
  logic vld_d = 1'b0;

  uart_rx_frame_ctrl #(
    .SYNC_STAGES (2),
    .CD_W        (13)
  ) dut (
    .clk_i               (clk_i),
    .rst_ni              (rst_ni),
    .UART_RXD            (UART_RXD),
    .RXen                (RXen),
    .cd                  (cd),
    .number_data_receive (number_data_receive),
    .parity_bit_mode     (parity_bit_mode),
    .parity_odd          (parity_odd),
    .stop_bit_twice      (stop_bit_twice),
    .rx_data             (rx_data),
    .rx_valid            (rx_valid),
    .rx_ready            (rx_ready),
    .parity_err          (parity_err),
    .frame_err           (frame_err),
    .overrun_err         (overrun_err),
    .busy                (busy)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Event recorder: rx_valid rising edges, valid cycles and overrun pulses.
  always @(negedge clk_i) begin
    if (rx_valid && !vld_d) begin
      rise_cnt <= rise_cnt + 1;
      rise_cyc <= cyc;
    end
    vld_d <= rx_valid;
    if (rx_valid) vld_cnt <= vld_cnt + 1;
    if (overrun_err) ovr_cnt <= ovr_cnt + 1;
  end

  task automatic set_cfg(input int cdv, input int nb, input bit pe, input bit po, input bit s2);
    cd = 13'(cdv);
    number_data_receive = 4'(nb);
    parity_bit_mode = pe;
    parity_odd = po;
    stop_bit_twice = s2;
  endtask

  // Drives one frame, each bit lasting cdv cycles, changing the line at negedges.
  // c0 is the cycle in which the start bit begins. A zero stop level is left on the line.
  task automatic send_frame(input logic [7:0] d, input int nb, input int cdv,
                            input bit pe, input bit pbit, input int nstop,
                            input bit stop_val, output int c0);
    @(negedge clk_i);
    c0 = cyc;
    UART_RXD = 1'b0;
    repeat (cdv) @(negedge clk_i);
    for (int i = 0; i < nb; i++) begin
      UART_RXD = d[i];
      repeat (cdv) @(negedge clk_i);
    end
    if (pe) begin
      UART_RXD = pbit;
      repeat (cdv) @(negedge clk_i);
    end
    for (int s = 0; s < nstop; s++) begin
      UART_RXD = stop_val;
      repeat (cdv) @(negedge clk_i);
    end
    if (stop_val) UART_RXD = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_i);
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
    checks++; if ({parity_err, frame_err, overrun_err} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {parity_err, frame_err, overrun_err}); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    @(negedge clk_i);
    rst_ni = 1'b1;
    RXen = 1'b1;
    repeat (5) @(negedge clk_i);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_basic_8n1();
    int c0, r0, v0;
    set_cfg(4, 8, 0, 0, 0);
    rx_ready = 1'b1;
    r0 = rise_cnt; v0 = vld_cnt;
    send_frame(8'hA5, 8, 4, 0, 0, 1, 1, c0);
    repeat (8) @(negedge clk_i);
    checks++; if (rise_cnt - r0 !== 1) begin errors++; $display("FAIL 8n1_frames: got %0d want 1", rise_cnt - r0); end
    checks++; if (vld_cnt - v0 !== 1) begin errors++; $display("FAIL 8n1_valid_width: got %0d want 1", vld_cnt - v0); end
    checks++; if (rise_cyc !== c0 + 41) begin errors++; $display("FAIL 8n1_latency: got %0d want %0d", rise_cyc - c0, 41); end
    checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL 8n1_data: got %h want a5", rx_data); end
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL 8n1_perr: got %b want 0", parity_err); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL 8n1_ferr: got %b want 0", frame_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL 8n1_busy: got %b want 0", busy); end
  endtask

  task automatic test_parity_7e2();
    int c0, r0;
    set_cfg(8, 7, 1, 0, 1);
    r0 = rise_cnt;
    // 0x55 in 7 bits has four ones; even parity needs 0, so 1 is wrong.
    send_frame(8'h55, 7, 8, 1, 1, 2, 1, c0);
    repeat (8) @(negedge clk_i);
    checks++; if (rise_cnt - r0 !== 1) begin errors++; $display("FAIL 7e2_frames: got %0d want 1", rise_cnt - r0); end
    checks++; if (rise_cyc !== c0 + 87) begin errors++; $display("FAIL 7e2_latency: got %0d want 87", rise_cyc - c0); end
    checks++; if (rx_data !== 8'h55) begin errors++; $display("FAIL 7e2_data: got %h want 55", rx_data); end
    checks++; if (parity_err !== 1'b1) begin errors++; $display("FAIL 7e2_perr: got %b want 1", parity_err); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL 7e2_ferr: got %b want 0", frame_err); end
  endtask

  task automatic test_break();
    int c0, r0;
    set_cfg(4, 8, 0, 0, 0);
    r0 = rise_cnt;
    send_frame(8'h0F, 8, 4, 0, 0, 1, 0, c0);
    repeat (40) @(negedge clk_i);
    checks++; if (rise_cnt - r0 !== 1) begin errors++; $display("FAIL break_frames: got %0d want 1", rise_cnt - r0); end
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL break_ferr: got %b want 1", frame_err); end
    checks++; if (rx_data !== 8'h0F) begin errors++; $display("FAIL break_data: got %h want 0f", rx_data); end
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL break_perr: got %b want 0", parity_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL break_retrigger_busy: got %b want 0", busy); end
    UART_RXD = 1'b1;
    repeat (10) @(negedge clk_i);
    checks++; if (rise_cnt - r0 !== 1) begin errors++; $display("FAIL break_release_frames: got %0d want 1", rise_cnt - r0); end
  endtask

  task automatic test_glitch();
    int r0;
    set_cfg(6, 8, 0, 0, 0);
    r0 = rise_cnt;
    @(negedge clk_i);
    UART_RXD = 1'b0;
    @(negedge clk_i);
    UART_RXD = 1'b1;
    repeat (2) @(negedge clk_i);   // t0 + 1
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_start: got %b want 1", busy); end
    repeat (3) @(negedge clk_i);   // t0 + 4, after the start sample at t0 + 3
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_end: got %b want 0", busy); end
    repeat (30) @(negedge clk_i);
    checks++; if (rise_cnt - r0 !== 0) begin errors++; $display("FAIL glitch_frames: got %0d want 0", rise_cnt - r0); end
  endtask

  task automatic test_min_cd_5o1();
    int c0, r0;
    // cd=1 clamps to 2; 0x13 in 5 bits has three ones, odd parity bit is 0.
    set_cfg(1, 5, 1, 1, 0);
    r0 = rise_cnt;
    send_frame(8'h13, 5, 2, 1, 0, 1, 1, c0);
    repeat (6) @(negedge clk_i);
    checks++; if (rise_cnt - r0 !== 1) begin errors++; $display("FAIL mincd_frames: got %0d want 1", rise_cnt - r0); end
    checks++; if (rise_cyc !== c0 + 18) begin errors++; $display("FAIL mincd_latency: got %0d want 18", rise_cyc - c0); end
    checks++; if (rx_data !== 8'h13) begin errors++; $display("FAIL mincd_data: got %h want 13", rx_data); end
    checks++; if ({parity_err, frame_err} !== 2'b00) begin errors++; $display("FAIL mincd_flags: got %b want 00", {parity_err, frame_err}); end
  endtask

  task automatic test_back_to_back_overrun();
    int c0, o0;
    set_cfg(4, 8, 0, 0, 0);
    rx_ready = 1'b0;
    o0 = ovr_cnt;
    send_frame(8'h11, 8, 4, 0, 0, 1, 1, c0);
    repeat (4) @(negedge clk_i);
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_first_valid: got %b want 1", rx_valid); end
    checks++; if (rx_data !== 8'h11) begin errors++; $display("FAIL ovr_first_data: got %h want 11", rx_data); end
    checks++; if (ovr_cnt - o0 !== 0) begin errors++; $display("FAIL ovr_first_pulse: got %0d want 0", ovr_cnt - o0); end
    send_frame(8'h22, 8, 4, 0, 0, 1, 1, c0);
    repeat (4) @(negedge clk_i);
    checks++; if (rx_data !== 8'h22) begin errors++; $display("FAIL ovr_second_data: got %h want 22", rx_data); end
    checks++; if (ovr_cnt - o0 !== 1) begin errors++; $display("FAIL ovr_pulse_cycles: got %0d want 1", ovr_cnt - o0); end
    repeat (10) @(negedge clk_i);
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid_hold: got %b want 1", rx_valid); end
    rx_ready = 1'b1;
    @(negedge clk_i);
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ovr_accept_clear: got %b want 0", rx_valid); end
    checks++; if (rx_data !== 8'h22) begin errors++; $display("FAIL ovr_data_after_accept: got %h want 22", rx_data); end
  endtask

  task automatic test_rxen_abort();
    int c0, r0;
    set_cfg(4, 8, 0, 0, 0);
    rx_ready = 1'b1;
    r0 = rise_cnt;
    @(negedge clk_i);
    UART_RXD = 1'b0;                 // start bit, then data bits 0..2 all zero
    repeat (16) @(negedge clk_i);
    repeat (2) @(negedge clk_i);     // inside data bit 3
    RXen = 1'b0;
    repeat (2) @(negedge clk_i);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
    UART_RXD = 1'b1;
    repeat (10) @(negedge clk_i);
    RXen = 1'b1;
    repeat (4) @(negedge clk_i);
    checks++; if (rise_cnt - r0 !== 0) begin errors++; $display("FAIL abort_frames: got %0d want 0", rise_cnt - r0); end
    send_frame(8'h3C, 8, 4, 0, 0, 1, 1, c0);
    repeat (6) @(negedge clk_i);
    checks++; if (rise_cnt - r0 !== 1) begin errors++; $display("FAIL abort_next_frames: got %0d want 1", rise_cnt - r0); end
    checks++; if (rise_cyc !== c0 + 41) begin errors++; $display("FAIL abort_next_latency: got %0d want 41", rise_cyc - c0); end
    checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL abort_next_data: got %h want 3c", rx_data); end
  endtask

  task automatic test_reset_midframe();
    set_cfg(4, 8, 0, 0, 0);
    @(negedge clk_i);
    UART_RXD = 1'b0;
    repeat (10) @(negedge clk_i);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b want 1", busy); end
    rst_ni = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL midrst_data: got %h want 00", rx_data); end
    checks++; if ({rx_valid, parity_err, frame_err, overrun_err} !== 4'b0000) begin errors++; $display("FAIL midrst_flags: got %b want 0000", {rx_valid, parity_err, frame_err, overrun_err}); end
    UART_RXD = 1'b1;
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (5) @(negedge clk_i);
  endtask

  initial begin
    test_reset();
    test_basic_8n1();
    test_parity_7e2();
    test_break();
    test_glitch();
    test_min_cd_5o1();
    test_back_to_back_overrun();
    test_rxen_abort();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
